// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings
// and the default operand width (Hack word size).
// Optional feature macro: SERIAL_SUBTRACTOR_FLAGS_EN (zr/ng flag outputs).
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor built from two half-subtractor stages.
// d = a - b - bin (mod 2), bout = borrow out of this bit position.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d1;
    logic b1;
    logic b2;

    // First half subtractor a - b, second subtracts the incoming borrow
    always_comb begin
        d1   = a ^ b;
        b1   = ~a & b;
        d    = d1 ^ bin;
        b2   = ~d1 & bin;
        bout = b1 | b2;
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b, one bit per clock, LSB
// first, through a single full-subtractor cell. start/done handshake.
// Optional feature macro: SERIAL_SUBTRACTOR_FLAGS_EN adds registered
// zr (diff == 0) and ng (diff MSB) outputs.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
    output logic             zr,
    output logic             ng,
`endif
    output logic             borrow
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] diff_sr;
    logic             bin;
    logic [CW-1:0]    count;

    logic             d;
    logic             bout;
    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] diff_shift;

    full_subtractor u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (bin),
        .d    (d),
        .bout (bout)
    );

    // Handshake decode and the result register with the new bit at its MSB
    always_comb begin
        accept     = start && ((state == IDLE) || (state == DONE));
        last_bit   = (count == CW'(WIDTH - 1));
        diff_shift = (diff_sr >> 1) | (WIDTH'(d) << (WIDTH - 1));
    end

    // Control FSM and serial datapath; result outputs change only on entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            diff    <= '0;
            borrow  <= 1'b0;
            a_sr    <= '0;
            b_sr    <= '0;
            diff_sr <= '0;
            bin     <= 1'b0;
            count   <= '0;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
            zr      <= 1'b0;
            ng      <= 1'b0;
`endif
        end else if (accept) begin
            // Load from IDLE, or back-to-back from DONE
            state <= RUN;
            busy  <= 1'b1;
            done  <= 1'b0;
            a_sr  <= a;
            b_sr  <= b;
            bin   <= 1'b0;
            count <= '0;
        end else begin
            case (state)
                RUN: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    diff_sr <= diff_shift;
                    bin     <= bout;
                    count   <= count + CW'(1);
                    if (last_bit) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        diff   <= diff_shift;
                        borrow <= bout;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
                        zr     <= (diff_shift == '0);
                        ng     <= d;
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed and random operands
// compared against plain modular arithmetic, plus a WIDTH=1 instance.
// Honours SERIAL_SUBTRACTOR_FLAGS_EN when defined.
module tb_serial_subtractor;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
    logic         zr;
    logic         ng;
`endif

    logic         start1 = 1'b0;
    logic [0:0]   a1 = '0;
    logic [0:0]   b1 = '0;
    logic         busy1;
    logic         done1;
    logic [0:0]   diff1;
    logic         borrow1;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
    logic         zr1;
    logic         ng1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
        .zr     (zr),
        .ng     (ng),
`endif
        .borrow (borrow)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start1),
        .a      (a1),
        .b      (b1),
        .busy   (busy1),
        .done   (done1),
        .diff   (diff1),
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
        .zr     (zr1),
        .ng     (ng1),
`endif
        .borrow (borrow1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one subtraction on the WIDTH=16 instance. Must be entered #1 after
    // a rising edge; returns #1 after the edge that enters DONE, so calling it
    // again immediately exercises back-to-back starts.
    // poke: raise start with other operands mid-RUN (must be ignored).
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input bit poke, input string tag);
        logic [W-1:0] exp_d;
        logic         exp_b;
        int           ia;
        int           ib;
        int           id;
        ia    = int'(av);
        ib    = int'(bv);
        id    = ia - ib;
        exp_d = W'(id + 65536);
        exp_b = (ia < ib);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(posedge clk); #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        chk({tag, ".busy_after_start"}, 32'(busy), 32'd1);
        for (int i = 1; i < W; i++) begin
            if (poke && i == 3) begin
                start = 1'b1;
                a     = 16'd1;
                b     = 16'd2;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            chk({tag, ".busy_run"}, 32'(busy), 32'd1);
            chk({tag, ".done_run"}, 32'(done), 32'd0);
        end
        start = 1'b0;
        @(posedge clk); #1;
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".busy_done"}, 32'(busy), 32'd0);
        chk({tag, ".diff"}, 32'(diff), 32'(exp_d));
        chk({tag, ".borrow"}, 32'(borrow), 32'(exp_b));
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
        chk({tag, ".zr"}, 32'(zr), 32'(exp_d == '0));
        chk({tag, ".ng"}, 32'(ng), 32'(exp_d[W-1]));
`endif
    endtask

    // One operation on the WIDTH=1 instance; same entry/exit timing.
    task automatic run_op1(input logic av, input logic bv, input string tag);
        int expv;
        expv   = int'(av) - int'(bv);
        start1 = 1'b1;
        a1     = av;
        b1     = bv;
        @(posedge clk); #1;
        start1 = 1'b0;
        chk({tag, ".busy"}, 32'(busy1), 32'd1);
        chk({tag, ".done_early"}, 32'(done1), 32'd0);
        @(posedge clk); #1;
        chk({tag, ".done"}, 32'(done1), 32'd1);
        chk({tag, ".diff"}, 32'(diff1), 32'(expv & 1));
        chk({tag, ".borrow"}, 32'(borrow1), 32'(expv < 0));
    endtask

    task automatic idle(input int n, input logic [W-1:0] hold_d, input string tag);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            chk({tag, ".idle_done"}, 32'(done), 32'd0);
            chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
            chk({tag, ".idle_diff"}, 32'(diff), 32'(hold_d));
        end
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] last_d;
        int           seen_done;

        // Reset state
        #12;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.diff", 32'(diff), 32'd0);
        chk("rst.borrow", 32'(borrow), 32'd0);
        chk("rst.busy1", 32'(busy1), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        run_op(16'd5, 16'd3, 1'b0, "5-3");
        idle(1, 16'h0002, "after5-3");
        run_op(16'd3, 16'd5, 1'b0, "3-5");
        idle(1, 16'hFFFE, "after3-5");
        run_op(16'h8000, 16'h0001, 1'b0, "8000-1");
        idle(1, 16'h7FFF, "after8000-1");
        run_op(16'h1234, 16'h1234, 1'b0, "eq");
        idle(5, 16'h0000, "hold0");

        // start during RUN ignored, then back-to-back start in DONE cycle
        run_op(16'd10, 16'd4, 1'b1, "10-4poke");
        run_op(16'd7, 16'd7, 1'b0, "b2b7-7");
        idle(1, 16'h0000, "afterb2b");

        // Boundary operands
        run_op(16'h0000, 16'hFFFF, 1'b0, "0-FFFF");
        run_op(16'hFFFF, 16'h0000, 1'b0, "FFFF-0");
        idle(2, 16'hFFFF, "afterFFFF");

        // Random operands with random gaps (0 = back-to-back)
        for (int n = 0; n < 12; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (n % 3 == 0) rb = ra + W'($urandom_range(0, 2));
            run_op(ra, rb, ($urandom_range(0, 3) == 0), "rand");
            last_d = ra - rb;
            idle($urandom_range(0, 2), last_d, "rand_gap");
        end

        // Make the held result non-zero so the reset clear is visible
        run_op(16'h0100, 16'h0001, 1'b0, "pre_rst");

        // Asynchronous reset mid-RUN, between edges 8 and 9
        start = 1'b1;
        a     = 16'hABCD;
        b     = 16'h1111;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.busy", 32'(busy), 32'd0);
        chk("arst.done", 32'(done), 32'd0);
        chk("arst.diff", 32'(diff), 32'd0);
        chk("arst.borrow", 32'(borrow), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen_done++;
        end
        chk("arst.no_done", 32'(seen_done), 32'd0);
        chk("arst.idle_busy", 32'(busy), 32'd0);
        run_op(16'h4321, 16'h1234, 1'b0, "post_rst");

        // WIDTH=1 instance, all operand pairs
        run_op1(1'b0, 1'b1, "w1_0-1");
        run_op1(1'b1, 1'b0, "w1_1-0");
        run_op1(1'b1, 1'b1, "w1_1-1");
        run_op1(1'b0, 1'b0, "w1_0-0");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
